// File: rtl/led_vector_checker.sv
// led_vector_checker
//
// On-chip sweep generator and response checker for a switch-to-LED
// pass-through block. Every pattern 0 .. 2^WIDTH-1 is driven onto sw_out.
// Each pattern is held for SETTLE_CYCLES cycles, and the returned led_in is
// compared in one extra CHECK cycle. Mismatches are counted and reported.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   level; begins a sweep when idle or when done is showing
//   sw_out       out  pattern driven to the checked block's switch inputs
//   led_in       in   checked block's LED outputs
//   busy         out  sweep in progress
//   done         out  sweep finished; held until the next start or reset
//   pass         out  valid while done; 1 when no mismatch was seen
//   error_count  out  number of mismatches in the current or last sweep
//   fail_valid   out  one-cycle pulse per mismatch
//   fail_vector  out  pattern of the most recent mismatch
//   fail_value   out  led_in captured at the most recent mismatch
module led_vector_checker #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] sw_out,
    input  logic [WIDTH-1:0] led_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   error_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_vector,
    output logic [WIDTH-1:0] fail_value
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]    SETTLE_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] VEC_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] vector_r;
    logic [CW-1:0]    settle_r;
    // A mismatch found in CHECK is posted here and reported one edge later,
    // so fail_valid and error_count move together.
    logic             pend_r;
    logic [WIDTH:0]   error_count_r;
    logic             fail_valid_r;
    logic [WIDTH-1:0] fail_vector_r;
    logic [WIDTH-1:0] fail_value_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             start_ok_s;
    logic             last_vec_s;
    logic             settle_end_s;
    logic             mismatch_s;
    logic [WIDTH:0]   count_next_s;

    // Qualify start and decode the per-vector conditions.
    // DONE accepts start only once done is visible. The first DONE cycle
    // retires the final pending mismatch.
    always_comb begin
        start_ok_s = 1'b0;
        if (state_r == IDLE) begin
            start_ok_s = start;
        end else if (state_r == DONE) begin
            start_ok_s = start & done_r;
        end else begin
            start_ok_s = 1'b0;
        end
        last_vec_s   = (vector_r == {WIDTH{1'b1}});
        settle_end_s = (settle_r == SETTLE_LAST);
        mismatch_s   = (led_in != vector_r);
        count_next_s = error_count_r + {{WIDTH{1'b0}}, pend_r};
    end

    // Sweep state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                if (settle_end_s) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = DRIVE;
                end
            end
            CHECK: begin
                if (last_vec_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRIVE;
                end
            end
            DONE: begin
                if (start_ok_s) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Vector and settle counters, mismatch capture, and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vector_r      <= {WIDTH{1'b0}};
            settle_r      <= {CW{1'b0}};
            pend_r        <= 1'b0;
            error_count_r <= {(WIDTH + 1){1'b0}};
            fail_valid_r  <= 1'b0;
            fail_vector_r <= {WIDTH{1'b0}};
            fail_value_r  <= {WIDTH{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
        end else begin
            fail_valid_r  <= pend_r;
            error_count_r <= count_next_s;
            pend_r        <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        vector_r      <= {WIDTH{1'b0}};
                        settle_r      <= {CW{1'b0}};
                        error_count_r <= {(WIDTH + 1){1'b0}};
                        fail_valid_r  <= 1'b0;
                        fail_vector_r <= {WIDTH{1'b0}};
                        fail_value_r  <= {WIDTH{1'b0}};
                        busy_r        <= 1'b1;
                        done_r        <= 1'b0;
                        pass_r        <= 1'b0;
                    end else if ((state_r == DONE) && !done_r) begin
                        // Finalise: the last pending mismatch lands in the count on this edge.
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (count_next_s == {(WIDTH + 1){1'b0}});
                    end
                end
                DRIVE: begin
                    settle_r <= settle_r + SETTLE_ONE;
                end
                CHECK: begin
                    if (mismatch_s) begin
                        pend_r        <= 1'b1;
                        fail_vector_r <= vector_r;
                        fail_value_r  <= led_in;
                    end
                    if (!last_vec_s) begin
                        vector_r <= vector_r + VEC_ONE;
                        settle_r <= {CW{1'b0}};
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign sw_out      = vector_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign error_count = error_count_r;
    assign fail_valid  = fail_valid_r;
    assign fail_vector = fail_vector_r;
    assign fail_value  = fail_value_r;

endmodule

// File: tb/tb_led_vector_checker.sv
// tb_led_vector_checker
//
// Directed bench for led_vector_checker. A behavioural model of the
// switch/LED block sits on the feedback path. It can act as identity, LED3
// stuck at 0, inverted, or LED0 stuck at 1. A table gives each mode's
// expected sweep summary. Hand-written sequences cover these cases:
// - reset in the middle of a sweep
// - start held high through a sweep
// - a small 4-bit instance with SETTLE_CYCLES = 1
module tb_led_vector_checker;

    localparam int W = 8;
    localparam int S = 5;
    localparam int DONE_EDGES = 1 + (1 << W) * (S + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] sw_out;
    logic [W-1:0] led_in;
    logic         busy, done, pass, fail_valid;
    logic [W:0]   error_count;
    logic [W-1:0] fail_vector, fail_value;
    int           mode;

    logic         start2;
    logic [3:0]   sw2, led2, fvec2, fval2;
    logic         busy2, done2, pass2, fv2;
    logic [4:0]   ec2;

    int tests = 0;
    int fails = 0;

    int pulses, first_vec, first_val, last_vec, last_val, sp_err;

    always #5 clk = ~clk;

    // Model of the checked block on the feedback path.
    always_comb begin
        case (mode)
            0:       led_in = sw_out;
            1:       led_in = sw_out & 8'hF7;
            2:       led_in = ~sw_out;
            3:       led_in = sw_out | 8'h01;
            default: led_in = sw_out;
        endcase
    end

    assign led2 = sw2;

    led_vector_checker #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .sw_out(sw_out), .led_in(led_in),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .fail_valid(fail_valid), .fail_vector(fail_vector), .fail_value(fail_value)
    );

    led_vector_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .sw_out(sw2), .led_in(led2),
        .busy(busy2), .done(done2), .pass(pass2), .error_count(ec2),
        .fail_valid(fv2), .fail_vector(fvec2), .fail_value(fval2)
    );

    typedef struct {
        int mode;
        int errors;
        int pass_exp;
        int pulses;
        int first_vec;
        int first_val;
        int last_vec;
        int last_val;
        int spacing;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, then follow the sweep edge by edge and log the fail pulses.
    task automatic run_sweep(input int spacing, output int done_cyc);
        int prev;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("sw_out_after_start", sw_out, 0);
        pulses = 0; first_vec = -1; first_val = -1; last_vec = -1; last_val = -1;
        sp_err = 0; prev = -1; done_cyc = -1;
        for (int c = 1; c <= 2000 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            if (fail_valid) begin
                if (pulses == 0) begin
                    first_vec = int'(fail_vector);
                    first_val = int'(fail_value);
                end
                last_vec = int'(fail_vector);
                last_val = int'(fail_value);
                if (spacing > 0 && prev >= 0 && (c - prev) != spacing) sp_err++;
                prev = c;
                pulses++;
            end
            if (done) done_cyc = c;
        end
        if (done_cyc < 0) chk("sweep_timeout", 0, 1);
    endtask

    initial begin
        int dc;
        int busy_bad;

        tbl[0] = '{0,   0, 1,   0, -1,  -1,  -1,  -1, 0};
        tbl[1] = '{1, 128, 0, 128,  8,   0, 255, 247, 0};
        tbl[2] = '{2, 256, 0, 256,  0, 255, 255,   0, 6};
        tbl[3] = '{3, 128, 0, 128,  0,   1, 254, 255, 12};

        mode = 0; rst = 1'b1; start = 1'b0; start2 = 1'b0;
        #23;
        chk("rst_sw_out", sw_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_fail_valid", fail_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweeps against each model of the checked block.
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_sweep(tbl[i].spacing, dc);
            chk("done_latency", dc, DONE_EDGES);
            chk("error_count", error_count, tbl[i].errors);
            chk("pass", pass, tbl[i].pass_exp);
            chk("busy_at_done", busy, 0);
            chk("fail_pulses", pulses, tbl[i].pulses);
            if (tbl[i].first_vec >= 0) begin
                chk("first_fail_vector", first_vec, tbl[i].first_vec);
                chk("first_fail_value", first_val, tbl[i].first_val);
                chk("last_fail_vector", last_vec, tbl[i].last_vec);
                chk("last_fail_value", last_val, tbl[i].last_val);
            end
            if (tbl[i].spacing > 0) chk("fail_spacing_errors", sp_err, 0);
            @(posedge clk);
            #1;
            chk("done_held", done, 1);
            chk("fail_valid_one_cycle", fail_valid, 0);
            chk("sw_out_holds_last", sw_out, 255);
        end

        // Reset in the middle of a sweep (inverted model, so state is dirty).
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 1000 && sw_out != 8'd100; c++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_vector_100", sw_out, 100);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sw_out", sw_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_error_count", error_count, 0);
        chk("midrst_fail_vector", fail_vector, 0);
        chk("midrst_fail_value", fail_value, 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run_sweep(0, dc);
        chk("after_rst_done_latency", dc, DONE_EDGES);
        chk("after_rst_error_count", error_count, 0);
        chk("after_rst_pass", pass, 1);

        // Start held high for a whole sweep: no restart while busy.
        mode = 2;
        busy_bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c < DONE_EDGES; c++) begin
            @(posedge clk);
            #1;
            if (!busy || done) busy_bad++;
        end
        chk("held_start_busy_glitches", busy_bad, 0);
        @(posedge clk);
        #1;
        chk("held_done", done, 1);
        chk("held_error_count", error_count, 256);
        @(posedge clk);
        #1;
        chk("held_restart_busy", busy, 1);
        chk("held_restart_done", done, 0);
        chk("held_restart_count", error_count, 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Small instance: WIDTH=4, SETTLE_CYCLES=1, identity.
        dc = -1;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 1; c <= 200 && dc < 0; c++) begin
            @(posedge clk);
            #1;
            if (done2) dc = c;
        end
        chk("small_done_latency", dc, 33);
        chk("small_pass", pass2, 1);
        chk("small_error_count", ec2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
